// File: rtl/clock_pkg.sv
// Shared BCD types, constants and helpers for the clock counter stages.
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX             = 4'd9;
    localparam int         DEFAULT_MODULUS_SEC = 60;
    localparam int         DEFAULT_MODULUS_HR  = 24;

    function automatic logic bcd_is_valid(input bcd_digit_t nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register: load > clear > increment > decrement, wraps 9<->0.
module bcd_digit
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    output bcd_digit_t q,
    output logic       wrap9,
    output logic       at0
);

    bcd_digit_t q_q, q_d;

    assign wrap9 = (q_q == BCD_MAX);
    assign at0   = (q_q == 4'd0);
    assign q     = q_q;

    always_comb begin
        q_d = q_q;
        if (ld)
            q_d = ld_val;
        else if (clr)
            q_d = 4'd0;
        else if (inc)
            q_d = wrap9 ? 4'd0 : q_q + 4'd1;
        else if (dec)
            q_d = at0 ? BCD_MAX : q_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!res)
            q_q <= 4'd0;
        else
            q_q <= q_d;
    end

endmodule

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD modulo counter with preload check, terminal flag and carry chain.
// Optional down counting is compiled in with the COUNTER_DOWN_EN macro.
module bcd_pair_counter
    import clock_pkg::*;
#(
    parameter int MODULUS = DEFAULT_MODULUS_SEC,
    parameter int TENS_W  = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic              ena,
    input  logic              load,
    input  logic [7:0]        load_val,
    input  logic              dir_down,
    output logic [3:0]        cnt_ones,
    output logic [TENS_W-1:0] cnt_tens,
    output logic              max,
    output logic              carry,
    output logic              load_err
);

    localparam bcd_digit_t TERM_ONES = bcd_digit_t'((MODULUS - 1) % 10);
    localparam bcd_digit_t TERM_TENS = bcd_digit_t'((MODULUS - 1) / 10);

    bcd_digit_t ones_q, tens_q;
    logic       ones_wrap9, ones_at0, tens_wrap9, tens_at0;
    logic       ones_inc, ones_dec, ones_ld, tens_inc, tens_dec, tens_ld, clr;
    bcd_digit_t ones_ld_val, tens_ld_val;
    logic       down, at_top, at_zero, ld_ok, cnt, load_err_q;
    logic [7:0] ld_bin;

`ifdef COUNTER_DOWN_EN
    assign down = dir_down;
`else
    logic unused_dir;
    assign unused_dir = dir_down;
    assign down       = 1'b0;
`endif

    assign at_top  = (ones_q == TERM_ONES) && (tens_q == TERM_TENS);
    assign at_zero = ones_at0 && tens_at0;
    assign max     = down ? at_zero : at_top;

    assign ld_bin = {4'd0, load_val[7:4]} * 8'd10 + {4'd0, load_val[3:0]};
    assign ld_ok  = bcd_is_valid(load_val[3:0]) && bcd_is_valid(load_val[7:4])
                 && (ld_bin < 8'(MODULUS));

    // A load cycle swallows ena, so neither the count nor the carry advances.
    assign cnt   = ena && !load;
    assign carry = res && cnt && max;

    always_comb begin
        ones_inc    = 1'b0;
        ones_dec    = 1'b0;
        tens_inc    = 1'b0;
        tens_dec    = 1'b0;
        clr         = 1'b0;
        ones_ld     = load && ld_ok;
        tens_ld     = load && ld_ok;
        ones_ld_val = load_val[3:0];
        tens_ld_val = load_val[7:4];
        if (cnt) begin
            if (max && down) begin
                ones_ld     = 1'b1;
                tens_ld     = 1'b1;
                ones_ld_val = TERM_ONES;
                tens_ld_val = TERM_TENS;
            end else if (max) begin
                clr = 1'b1;
            end else if (down) begin
                ones_dec = 1'b1;
                tens_dec = ones_at0;
            end else begin
                ones_inc = 1'b1;
                tens_inc = ones_wrap9;
            end
        end
    end

    bcd_digit u_ones (
        .clk    (clk),
        .res    (res),
        .inc    (ones_inc),
        .dec    (ones_dec),
        .clr    (clr),
        .ld     (ones_ld),
        .ld_val (ones_ld_val),
        .q      (ones_q),
        .wrap9  (ones_wrap9),
        .at0    (ones_at0)
    );

    bcd_digit u_tens (
        .clk    (clk),
        .res    (res),
        .inc    (tens_inc),
        .dec    (tens_dec),
        .clr    (clr),
        .ld     (tens_ld),
        .ld_val (tens_ld_val),
        .q      (tens_q),
        .wrap9  (tens_wrap9),
        .at0    (tens_at0)
    );

    always_ff @(posedge clk) begin
        if (!res)
            load_err_q <= 1'b0;
        else
            load_err_q <= load && !ld_ok;
    end

    assign load_err = load_err_q;
    assign cnt_ones = ones_q;
    assign cnt_tens = TENS_W'(tens_q);

    logic unused_tens_wrap9;
    assign unused_tens_wrap9 = tens_wrap9;

endmodule

// File: tb/tb_bcd_pair_counter.sv
// Bench: two cascaded mod-60 stages plus a mod-24 stage against an arithmetic model.
module tb_bcd_pair_counter;

`ifdef COUNTER_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res, dir;
    logic       ena_a, load_a, load_b, ena_c, load_c;
    logic [7:0] lv_a, lv_b, lv_c;
    logic [3:0] ones_a, ones_b, ones_c, tens_a, tens_b, tens_c;
    logic       max_a, max_b, max_c, carry_a, carry_b, carry_c;
    logic       err_a, err_b, err_c;

    int checks = 0, errors = 0;
    int va, vb, vc;
    bit ea, eb, ec;
    bit first;

    bcd_pair_counter #(.MODULUS(60)) u_a (
        .clk(clk), .res(res), .ena(ena_a), .load(load_a), .load_val(lv_a),
        .dir_down(dir), .cnt_ones(ones_a), .cnt_tens(tens_a), .max(max_a),
        .carry(carry_a), .load_err(err_a));

    bcd_pair_counter #(.MODULUS(60)) u_b (
        .clk(clk), .res(res), .ena(carry_a), .load(load_b), .load_val(lv_b),
        .dir_down(dir), .cnt_ones(ones_b), .cnt_tens(tens_b), .max(max_b),
        .carry(carry_b), .load_err(err_b));

    bcd_pair_counter #(.MODULUS(24)) u_c (
        .clk(clk), .res(res), .ena(ena_c), .load(load_c), .load_val(lv_c),
        .dir_down(dir), .cnt_ones(ones_c), .cnt_tens(tens_c), .max(max_c),
        .carry(carry_c), .load_err(err_c));

    function automatic bit valid(input logic [7:0] lv, input int m);
        return lv[7:4] <= 9 && lv[3:0] <= 9 && (int'(lv[7:4]) * 10 + int'(lv[3:0])) < m;
    endfunction

    function automatic int nxt(input int v, input int m, input bit r, input bit e,
                               input bit l, input logic [7:0] lv, input bit dn);
        if (!r) return 0;
        if (l) return valid(lv, m) ? int'(lv[7:4]) * 10 + int'(lv[3:0]) : v;
        if (e) return dn ? (v + m - 1) % m : (v + 1) % m;
        return v;
    endfunction

    function automatic bit term(input int v, input int m, input bit dn);
        return v == (dn ? 0 : m - 1);
    endfunction

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] b;
        b = {4'(v / 10), 4'(v % 10)};
        return b;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stage(input string s, input logic [3:0] o, input logic [3:0] t,
                             input logic mx, input logic le, input int v, input bit e,
                             input int m, input bit dn);
        chk({s, "_ones"}, 8'(o), 8'(v % 10));
        chk({s, "_tens"}, 8'(t), 8'(v / 10));
        chk({s, "_max"}, 8'(mx), 8'(term(v, m, dn)));
        chk({s, "_lerr"}, 8'(le), 8'(e));
    endtask

    // One clock: check combinational carry/max before the edge, registers after.
    task automatic cycle();
        bit dn, ca, cb, cc;
        dn = DOWN_EN && dir;
        ca = res && ena_a && !load_a && term(va, 60, dn);
        cb = res && ca && !load_b && term(vb, 60, dn);
        cc = res && ena_c && !load_c && term(vc, 24, dn);
        #1;
        if (!first) begin
            chk("carry_a", 8'(carry_a), 8'(ca));
            chk("carry_b", 8'(carry_b), 8'(cb));
            chk("carry_c", 8'(carry_c), 8'(cc));
            chk("max_a_pre", 8'(max_a), 8'(term(va, 60, dn)));
        end
        @(posedge clk);
        ea = res && load_a && !valid(lv_a, 60);
        eb = res && load_b && !valid(lv_b, 60);
        ec = res && load_c && !valid(lv_c, 24);
        va = nxt(va, 60, res, ena_a, load_a, lv_a, dn);
        vb = nxt(vb, 60, res, ca, load_b, lv_b, dn);
        vc = nxt(vc, 24, res, ena_c, load_c, lv_c, dn);
        #1;
        first = 1'b0;
        chk_stage("a", ones_a, tens_a, max_a, err_a, va, ea, 60, dn);
        chk_stage("b", ones_b, tens_b, max_b, err_b, vb, eb, 60, dn);
        chk_stage("c", ones_c, tens_c, max_c, err_c, vc, ec, 24, dn);
        @(negedge clk);
    endtask

    task automatic idle();
        res = 1'b1; ena_a = 1'b0; load_a = 1'b0; load_b = 1'b0;
        ena_c = 1'b0; load_c = 1'b0;
    endtask

    initial begin
        first = 1'b1;
        va = 0; vb = 0; vc = 0; ea = 0; eb = 0; ec = 0;
        dir = 1'b0; lv_a = 8'h00; lv_b = 8'h00; lv_c = 8'h00;
        idle();
        res = 1'b0;
        @(negedge clk);
        cycle();

        // Full mod-60 lap on stage a; b ticks once on the 59->00 rollover.
        idle();
        repeat (61) begin ena_a = 1'b1; cycle(); end

        // Mod-24: 23 -> 00 with carry, then a rejected out-of-range load.
        idle(); load_c = 1'b1; lv_c = 8'h23; cycle();
        idle(); ena_c = 1'b1; cycle();
        idle(); load_c = 1'b1; lv_c = 8'h24; cycle();
        idle(); cycle();

        // Invalid ones nibble together with ena.
        idle(); load_a = 1'b1; lv_a = 8'h3A; ena_a = 1'b1; cycle();
        idle(); cycle();

        // Cascade 59/59 rolls both stages on a single edge.
        idle(); load_a = 1'b1; lv_a = 8'h59; load_b = 1'b1; lv_b = 8'h59; cycle();
        idle(); ena_a = 1'b1; cycle();

        // Reset beats load and ena, counting resumes from 00.
        idle(); load_a = 1'b1; lv_a = 8'h37; cycle();
        idle(); res = 1'b0; load_a = 1'b1; lv_a = 8'h12; ena_a = 1'b1; cycle();
        idle(); ena_a = 1'b1; cycle(); cycle();

`ifdef COUNTER_DOWN_EN
        idle(); load_a = 1'b1; lv_a = 8'h00; cycle();
        idle(); dir = 1'b1; ena_a = 1'b1; cycle();
        idle(); dir = 1'b1; load_a = 1'b1; lv_a = 8'h10; cycle();
        idle(); dir = 1'b1; ena_a = 1'b1; cycle();
        idle(); dir = 1'b0; ena_a = 1'b1; cycle();
        idle(); dir = 1'b1; ena_a = 1'b1; cycle();
        idle(); dir = 1'b0; cycle();
`endif

        for (int i = 0; i < 400; i++) begin
            res    = ($urandom_range(0, 39) != 0);
            dir    = $urandom_range(0, 1) == 1;
            ena_a  = $urandom_range(0, 3) != 0;
            ena_c  = $urandom_range(0, 1) == 1;
            load_a = $urandom_range(0, 9) == 0;
            load_b = $urandom_range(0, 14) == 0;
            load_c = $urandom_range(0, 9) == 0;
            lv_a   = $urandom_range(0, 1) ? bcd($urandom_range(0, 59)) : 8'($urandom);
            lv_b   = $urandom_range(0, 1) ? bcd($urandom_range(0, 59)) : 8'($urandom);
            lv_c   = $urandom_range(0, 1) ? bcd($urandom_range(0, 29)) : 8'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
